// File: rtl/or_gate.sv
// or_gate: bitwise two-input OR primitive with a clocked observation stage.
//
// The combinational path (out) does not depend on clk or rst_n. The observation
// stage registers a copy of out, records whether any bit was high, tracks which
// {inA[0], inB[0]} combinations have occurred, and counts high cycles with
// saturation.
//
// Ports:
//   clk        - system clock, registers update on the rising edge
//   rst_n      - synchronous active-low reset
//   inA, inB   - operands (WIDTH bits)
//   out        - combinational inA | inB
//   out_q      - registered copy of out (1-cycle latency)
//   any_q      - registered reduction-OR of out
//   combo_seen - sticky coverage, bit index {inA[0], inB[0]}
//   hi_count   - saturating count of cycles where any bit of out was high
module or_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             any_q,
  output logic [3:0]       combo_seen,
  output logic [CNT_W-1:0] hi_count
);

  logic [1:0]       combo_idx;
  logic             any_hi;
  logic             cnt_sat;
  logic [3:0]       combo_seen_d;
  logic [CNT_W-1:0] hi_count_d;

  // Kept as a continuous assign so it stays live with an idle clock and X reset.
  assign out = inA | inB;

  always_comb begin
    combo_idx    = {inA[0], inB[0]};
    any_hi       = |out;
    cnt_sat      = &hi_count;
    combo_seen_d = combo_seen | (4'b0001 << combo_idx);
    hi_count_d   = hi_count;
    // Hold at all-ones rather than wrapping.
    if (any_hi && !cnt_sat) begin
      hi_count_d = hi_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      any_q      <= 1'b0;
      combo_seen <= 4'b0000;
      hi_count   <= '0;
    end else begin
      out_q      <= out;
      any_q      <= any_hi;
      combo_seen <= combo_seen_d;
      hi_count   <= hi_count_d;
    end
  end

endmodule

// File: tb/tb_or_gate.sv
// Bench for or_gate: three instances (default, CNT_W=4, WIDTH=8) driven together,
// checked against a behavioural model plus literal expectations for the corner cases.
module tb_or_gate;

  logic clk = 1'b0;
  bit   clk_run = 1'b0;
  logic rst_n;

  logic       a1, b1, o1, oq1, any1;
  logic [3:0] seen1;
  logic [7:0] cnt1;

  logic       as_, bs, os, oqs, anys;
  logic [3:0] seens;
  logic [3:0] cnts;

  logic [7:0] a8, b8, o8, oq8;
  logic       any8;
  logic [3:0] seen8;
  logic [7:0] cnt8;

  int checks = 0;
  int errors = 0;

  or_gate #(.WIDTH(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .inA(a1), .inB(b1), .out(o1), .out_q(oq1),
    .any_q(any1), .combo_seen(seen1), .hi_count(cnt1)
  );

  or_gate #(.WIDTH(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .inA(as_), .inB(bs), .out(os), .out_q(oqs),
    .any_q(anys), .combo_seen(seens), .hi_count(cnts)
  );

  or_gate #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .inA(a8), .inB(b8), .out(o8), .out_q(oq8),
    .any_q(any8), .combo_seen(seen8), .hi_count(cnt8)
  );

  always #5 if (clk_run) clk = ~clk;

  // Behavioural model, one slot per instance.
  logic [7:0] m_outq[3];
  logic       m_any[3];
  bit         m_seen[3][4];
  int         m_cnt[3];
  int         cap[3];
  logic [7:0] mask[3];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic get_in(input int id, output logic [7:0] a, output logic [7:0] b);
    case (id)
      0:       begin a = {7'd0, a1};  b = {7'd0, b1}; end
      1:       begin a = {7'd0, as_}; b = {7'd0, bs}; end
      default: begin a = a8;          b = b8;         end
    endcase
  endtask

  task automatic model_update();
    logic [7:0] a, b, o;
    for (int id = 0; id < 3; id++) begin
      get_in(id, a, b);
      if (rst_n == 1'b0) begin
        m_outq[id] = '0;
        m_any[id]  = 1'b0;
        for (int k = 0; k < 4; k++) m_seen[id][k] = 1'b0;
        m_cnt[id]  = 0;
      end else begin
        o = (a | b) & mask[id];
        m_outq[id] = o;
        m_any[id]  = (o != 0);
        m_seen[id][int'(a[0]) * 2 + int'(b[0])] = 1'b1;
        if (o != 0 && m_cnt[id] < cap[id]) m_cnt[id]++;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] a, b, act_o, act_q, act_c;
    logic       act_any;
    logic [3:0] act_s, exp_s;
    for (int id = 0; id < 3; id++) begin
      get_in(id, a, b);
      case (id)
        0:       begin act_o = {7'd0, o1}; act_q = {7'd0, oq1}; act_any = any1;
                       act_s = seen1; act_c = cnt1; end
        1:       begin act_o = {7'd0, os}; act_q = {7'd0, oqs}; act_any = anys;
                       act_s = seens; act_c = {4'd0, cnts}; end
        default: begin act_o = o8; act_q = oq8; act_any = any8;
                       act_s = seen8; act_c = cnt8; end
      endcase
      for (int k = 0; k < 4; k++) exp_s[k] = m_seen[id][k];
      chk($sformatf("out[%0d]", id), 32'(act_o), 32'((a | b) & mask[id]));
      chk($sformatf("out_q[%0d]", id), 32'(act_q), 32'(m_outq[id]));
      chk($sformatf("any_q[%0d]", id), 32'(act_any), 32'(m_any[id]));
      chk($sformatf("combo_seen[%0d]", id), 32'(act_s), 32'(exp_s));
      chk($sformatf("hi_count[%0d]", id), 32'(act_c), 32'(m_cnt[id]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic rand_others();
    as_ = 1'($urandom);
    bs  = 1'($urandom);
    a8  = 8'($urandom);
    b8  = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cap[0] = 255; cap[1] = 15; cap[2] = 255;
    mask[0] = 8'h01; mask[1] = 8'h01; mask[2] = 8'hFF;

    tbl[0] = '{a: 8'h00, b: 8'h00, exp: 8'h00};
    tbl[1] = '{a: 8'h00, b: 8'h01, exp: 8'h01};
    tbl[2] = '{a: 8'h01, b: 8'h00, exp: 8'h01};
    tbl[3] = '{a: 8'h01, b: 8'h01, exp: 8'h01};
    tbl[4] = '{a: 8'hA0, b: 8'h05, exp: 8'hA5};
    tbl[5] = '{a: 8'hFF, b: 8'h00, exp: 8'hFF};
    tbl[6] = '{a: 8'h3C, b: 8'hC3, exp: 8'hFF};
    tbl[7] = '{a: 8'h12, b: 8'h40, exp: 8'h52};

    // Combinational table: clock idle, rst_n never driven.
    as_ = 1'b0; bs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = tbl[i].a[0]; b1 = tbl[i].b[0];
      a8 = tbl[i].a;    b8 = tbl[i].b;
      #1;
      chk($sformatf("comb1 vec%0d", i), 32'(o1), 32'(tbl[i].exp[0]));
      chk($sformatf("comb8 vec%0d", i), 32'(o8), 32'(tbl[i].exp));
    end
    // A known 1 dominates an unknown operand.
    a1 = 1'b1; b1 = 1'bx;
    #1;
    chk("comb x dominated", 32'(o1), 32'd1);

    // Reset for two edges, then one clocked cycle.
    clk_run = 1'b1;
    a1 = 1'b0; b1 = 1'b0; rand_others();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst out_q", 32'(oq1), 32'd0);
    chk("rst any_q", 32'(any1), 32'd0);
    chk("rst combo_seen", 32'(seen1), 32'd0);
    chk("rst hi_count", 32'(cnt1), 32'd0);
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b0;
    a8 = 8'hA0; b8 = 8'h05;
    #1;
    chk("w8 out immediate", 32'(o8), 32'hA5);
    tick();
    chk("first out_q", 32'(oq1), 32'd1);
    chk("first any_q", 32'(any1), 32'd1);
    chk("first combo_seen", 32'(seen1), 32'b0100);
    chk("first hi_count", 32'(cnt1), 32'd1);
    chk("w8 out_q", 32'(oq8), 32'hA5);

    // Coverage and counting from a fresh reset.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a1 = c[1]; b1 = c[0]; rand_others();
      tick();
    end
    chk("cover combo_seen", 32'(seen1), 32'b1111);
    chk("cover hi_count", 32'(cnt1), 32'd3);
    a1 = 1'b0; b1 = 1'b0;
    repeat (5) tick();
    chk("idle hi_count", 32'(cnt1), 32'd3);
    chk("idle any_q", 32'(any1), 32'd0);

    // Saturation on the 4-bit counter instance.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; as_ = 1'b1; bs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      if (i == 14) chk("sat reach 15", 32'(cnts), 32'd15);
    end
    chk("sat hold 15", 32'(cnts), 32'd15);

    // Mid-run reset: reset beats the counting condition, out stays live.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b0;
    repeat (5) tick();
    chk("mid count 5", 32'(cnt1), 32'd5);
    rst_n = 1'b0; a1 = 1'b1; b1 = 1'b1;
    #1;
    chk("mid out before", 32'(o1), 32'd1);
    tick();
    chk("mid out_q", 32'(oq1), 32'd0);
    chk("mid any_q", 32'(any1), 32'd0);
    chk("mid combo_seen", 32'(seen1), 32'd0);
    chk("mid hi_count", 32'(cnt1), 32'd0);
    chk("mid out during", 32'(o1), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("resume hi_count", 32'(cnt1), 32'd1);
    chk("resume combo_seen", 32'(seen1), 32'b1000);

    // Randomised run with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      a1 = 1'($urandom); b1 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin a1 = 1'b0; b1 = 1'b0; end
      rand_others();
      if ($urandom_range(0, 3) == 0) begin a8 = 8'h00; b8 = 8'h00; end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
